// File: rtl/sat_accumulator.sv
// Streaming signed accumulator with per-add overflow detection.
// A run of `len` operands is summed into a registered accumulator; each add is
// clamped (SATURATE=1) or wrapped (SATURATE=0) on overflow, and a sticky flag
// records whether any add in the run overflowed. The result is held on a
// valid/ready output until the consumer takes it.
module sat_accumulator #(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned LEN_W    = 16,
    parameter bit          SATURATE = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic             abort,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             overflow,
    output logic             busy
);

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StAccum = 2'd1,
        StDone  = 2'd2
    } state_e;

    localparam logic [WIDTH-1:0] MaxPos = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] MinNeg = {1'b1, {(WIDTH-1){1'b0}}};

    state_e           state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;

    logic [WIDTH:0]   sum_ext;
    logic             add_ovf;

    // Sign-extended add; overflow when both operands share a sign the sum lacks.
    always_comb begin
        sum_ext = {acc_q[WIDTH-1], acc_q} + {in_data[WIDTH-1], in_data};
        add_ovf = (acc_q[WIDTH-1] == in_data[WIDTH-1]) &&
                  (sum_ext[WIDTH-1] != acc_q[WIDTH-1]);
    end

    // Next-state and datapath update; abort overrides every other transition.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        if (abort) begin
            // acc/ovf are left as-is; they are simply never presented as valid.
            state_d = StIdle;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        acc_d = '0;
                        ovf_d = 1'b0;
                        if (len != '0) begin
                            cnt_d   = len;
                            state_d = StAccum;
                        end else begin
                            state_d = StDone;
                        end
                    end
                end
                StAccum: begin
                    if (in_valid) begin
                        if (add_ovf) begin
                            ovf_d = 1'b1;
                            if (SATURATE) begin
                                acc_d = in_data[WIDTH-1] ? MinNeg : MaxPos;
                            end else begin
                                acc_d = sum_ext[WIDTH-1:0];
                            end
                        end else begin
                            acc_d = sum_ext[WIDTH-1:0];
                        end
                        cnt_d = cnt_q - LEN_W'(1);
                        if (cnt_q == LEN_W'(1)) begin
                            state_d = StDone;
                        end
                    end
                end
                StDone: begin
                    if (out_ready) begin
                        state_d = StIdle;
                    end
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end
    end

    // State and datapath registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            acc_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
        end
    end

    // Moore outputs decoded straight from registered state.
    always_comb begin
        in_ready  = (state_q == StAccum);
        out_valid = (state_q == StDone);
        busy      = (state_q == StAccum) || (state_q == StDone);
        result    = acc_q;
        overflow  = ovf_q;
    end

endmodule

// File: tb/tb_sat_accumulator.sv
// Self-checking bench: a saturating and a wrapping instance share stimulus;
// expected results are queued at run start and popped by a monitor on handoff.
module tb_sat_accumulator;

    localparam int W  = 32;
    localparam int LW = 16;
    localparam longint MAXV = 64'sd2147483647;
    localparam longint MINV = -64'sd2147483648;
    localparam longint MOD  = 64'sd4294967296;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic          in_valid = 1'b0;
    logic          out_ready = 1'b0;
    logic [LW-1:0] len = '0;
    logic [W-1:0]  in_data = '0;

    logic          in_ready_s, out_valid_s, overflow_s, busy_s;
    logic          in_ready_w, out_valid_w, overflow_w, busy_w;
    logic [W-1:0]  result_s, result_w;

    int checks = 0;
    int errors = 0;
    int acc_cnt = 0;

    typedef struct packed {
        logic [W-1:0] r;
        logic         o;
    } exp_t;

    exp_t exp_s[$];
    exp_t exp_w[$];
    exp_t e_s, e_w;
    int   q[$];

    always #5 clk = ~clk;

    sat_accumulator #(.WIDTH(W), .LEN_W(LW), .SATURATE(1'b1)) u_sat (
        .clk(clk), .rst_n(rst_n), .start(start), .len(len), .abort(abort),
        .in_valid(in_valid), .in_ready(in_ready_s), .in_data(in_data),
        .out_valid(out_valid_s), .out_ready(out_ready), .result(result_s),
        .overflow(overflow_s), .busy(busy_s)
    );

    sat_accumulator #(.WIDTH(W), .LEN_W(LW), .SATURATE(1'b0)) u_wrap (
        .clk(clk), .rst_n(rst_n), .start(start), .len(len), .abort(abort),
        .in_valid(in_valid), .in_ready(in_ready_w), .in_data(in_data),
        .out_valid(out_valid_w), .out_ready(out_ready), .result(result_w),
        .overflow(overflow_w), .busy(busy_w)
    );

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Reference: exact integer sum, then clamp or wrap whenever it leaves the range.
    function automatic exp_t model(input int ops[$], input bit sat);
        longint acc;
        longint s;
        exp_t   e;
        acc = 0;
        e.o = 1'b0;
        foreach (ops[i]) begin
            s = acc + longint'(ops[i]);
            if (s > MAXV || s < MINV) begin
                e.o = 1'b1;
                if (sat) acc = (s > MAXV) ? MAXV : MINV;
                else     acc = (s > MAXV) ? s - MOD : s + MOD;
            end else begin
                acc = s;
            end
        end
        e.r = acc[W-1:0];
        return e;
    endfunction

    function automatic int rand_op();
        case ($urandom_range(0, 3))
            0:       return int'(MAXV) - int'($urandom_range(0, 50));
            1:       return int'(32'h8000_0000) + int'($urandom_range(0, 50));
            2:       return int'($urandom_range(0, 2000)) - 1000;
            default: return int'($urandom());
        endcase
    endfunction

    // Monitor: counts accepts and checks every result handoff against the queues.
    always @(negedge clk) begin
        if (rst_n) begin
            if (in_valid && in_ready_s && !abort) acc_cnt++;
            if (out_valid_s && out_ready && !abort) begin
                if (exp_s.size() == 0) begin
                    chk("sat unexpected result", 1, 0);
                end else begin
                    e_s = exp_s.pop_front();
                    chk("sat result", result_s, e_s.r);
                    chk("sat overflow", overflow_s, e_s.o);
                end
            end
            if (out_valid_w && out_ready && !abort) begin
                if (exp_w.size() == 0) begin
                    chk("wrap unexpected result", 1, 0);
                end else begin
                    e_w = exp_w.pop_front();
                    chk("wrap result", result_w, e_w.r);
                    chk("wrap overflow", overflow_w, e_w.o);
                end
            end
        end
    end

    task automatic do_run(input int ops[$], input int unsigned n, input int gap_max,
                          input int abort_at, input int hold);
        int           base;
        bit           got;
        int           waited;
        logic [W-1:0] held_s, held_w;
        base = acc_cnt;
        if (abort_at < 0) begin
            exp_s.push_back(model(ops, 1'b1));
            exp_w.push_back(model(ops, 1'b0));
        end
        start = 1'b1;
        len   = LW'(n);
        @(posedge clk); #1;
        start = 1'b0;
        chk("busy after start", {busy_s, busy_w}, 2'b11);
        for (int i = 0; i < ops.size(); i++) begin
            repeat ($urandom_range(0, gap_max)) begin
                in_valid = 1'b0;
                @(posedge clk); #1;
            end
            in_valid = 1'b1;
            in_data  = ops[i];
            if (i == abort_at) begin
                abort = 1'b1;
                @(posedge clk); #1;
                abort    = 1'b0;
                in_valid = 1'b0;
                chk("abort to idle", {out_valid_s, busy_s, out_valid_w, busy_w}, 4'b0);
                repeat (3) @(posedge clk);
                #1;
                chk("abort no out_valid", {out_valid_s, out_valid_w}, 2'b00);
                return;
            end
            got    = 1'b0;
            waited = 0;
            while (!got && waited < 20) begin
                @(negedge clk);
                got = in_ready_s;
                @(posedge clk); #1;
                waited++;
            end
            if (!got) begin
                chk("in_ready timeout", 0, 1);
                in_valid = 1'b0;
                return;
            end
        end
        in_valid = 1'b0;
        chk("out_valid latency", {out_valid_s, out_valid_w}, 2'b11);
        held_s = result_s;
        held_w = result_w;
        // Offer data and a fresh start while DONE; both must be ignored.
        in_valid = 1'b1;
        in_data  = $urandom();
        for (int k = 0; k < hold; k++) begin
            start = (k == 1);
            len   = LW'(3);
            @(posedge clk); #1;
            chk("hold stable", {out_valid_s, out_valid_w, result_s, result_w},
                {2'b11, held_s, held_w});
        end
        out_ready = 1'b1;
        start     = 1'b1;
        len       = LW'(2);
        @(posedge clk); #1;
        out_ready = 1'b0;
        start     = 1'b0;
        in_valid  = 1'b0;
        chk("handoff to idle", {out_valid_s, busy_s, out_valid_w, busy_w}, 4'b0);
        chk("accept count", acc_cnt - base, n);
    endtask

    initial begin
        #1;
        chk("reset outputs", {in_ready_s, out_valid_s, busy_s, overflow_s, result_s,
                              in_ready_w, out_valid_w, busy_w, overflow_w, result_w}, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        q.delete(); q.push_back(int'(MAXV)); q.push_back(1);
        do_run(q, 2, 0, -1, 1);
        q.delete(); q.push_back(int'(32'h8000_0000)); q.push_back(-1);
        do_run(q, 2, 1, -1, 0);
        q.delete(); q.push_back(52); q.push_back(-31); q.push_back(152); q.push_back(2539);
        do_run(q, 4, 2, -1, 2);
        q.delete();
        do_run(q, 0, 0, -1, 5);
        q.delete(); q.push_back(int'(MAXV)); q.push_back(10); q.push_back(-100);
        do_run(q, 3, 1, -1, 1);

        q.delete(); q.push_back(1); q.push_back(2); q.push_back(3); q.push_back(4);
        do_run(q, 4, 1, 2, 0);
        q.delete(); q.push_back(7);
        do_run(q, 1, 0, -1, 0);

        // Asynchronous reset between clock edges in the middle of a run.
        start = 1'b1;
        len   = LW'(4);
        @(posedge clk); #1;
        start    = 1'b0;
        in_valid = 1'b1;
        in_data  = 32'd5;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("acc before reset", {result_s, busy_s}, {32'd5, 1'b1});
        #2;
        rst_n = 1'b0;
        #1;
        chk("async reset outputs", {in_ready_s, out_valid_s, busy_s, overflow_s, result_s,
                                    in_ready_w, out_valid_w, busy_w, overflow_w, result_w}, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        repeat (25) begin
            int unsigned n;
            n = $urandom_range(1, 6);
            q.delete();
            for (int i = 0; i < int'(n); i++) q.push_back(rand_op());
            do_run(q, n, 2, -1, $urandom_range(0, 3));
        end

        repeat (2) @(posedge clk);
        #1;
        chk("scoreboard drained", exp_s.size() + exp_w.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
